transmitter: RTL and testbench

UART transmit block: the transmit end of the serial link whose receive side deframes, shifts and parity-checks incoming bytes. It accepts one byte per request from the system side and drives a single serial line. Each frame is one start bit (0), 8 data bits LSB first, an optional odd-parity bit, and one stop bit (1). Bit timing comes from an internal divider on the single system clock.

---
 rtl/transmitter.sv | 172 +++++++++++++++++
 tb/tb_transmitter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// transmitter: UART transmit block.
// Sends one byte per request as start bit (0), 8 data bits LSB first,
// an optional odd-parity bit and a stop bit (1), with bit timing taken
// from an internal divider on the system clock.
// Build option: define TX_PARITY_EN to include the odd-parity bit
// (11-bit frame); leave it undefined for a 10-bit frame without parity.
module transmitter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] parallel_data_in,
    output logic       serial_data_out,
    output logic       busy,
    output logic       tx_done
);

    // Divider counts 0..CLKS_PER_BIT-1; keep at least one bit for tiny dividers.
    localparam int DIV_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic bitBoundary;

    // The current bit period ends on the edge where the divider reaches its last count.
    always_comb begin
        bitBoundary = (divCnt_q == DIV_LAST);
    end

    // Next-state and output decode: one bit period per state, data state repeated 8 times.
    always_comb begin
        state_d  = state_q;
        divCnt_d = divCnt_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        line_d   = line_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != IDLE) begin
            divCnt_d = bitBoundary ? '0 : divCnt_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d  = parallel_data_in;
                    busy_d   = 1'b1;
                    line_d   = 1'b0;
                    divCnt_d = '0;
                    bitCnt_d = 3'd0;
                    state_d  = START;
`ifdef TX_PARITY_EN
                    parity_d = ~^parallel_data_in;
`endif
                end
            end

            START: begin
                if (bitBoundary) begin
                    line_d   = shift_q[0];
                    bitCnt_d = 3'd0;
                    state_d  = DATA;
                end
            end

            DATA: begin
                if (bitBoundary) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitCnt_q == 3'd7) begin
                        bitCnt_d = 3'd0;
`ifdef TX_PARITY_EN
                        line_d  = parity_q;
                        state_d = PARITY;
`else
                        line_d  = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                        line_d   = shift_q[1];
                    end
                end
            end

`ifdef TX_PARITY_EN
            PARITY: begin
                if (bitBoundary) begin
                    line_d  = 1'b1;
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                if (bitBoundary) begin
                    line_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the line idle and drops any partial frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            divCnt_q <= '0;
            bitCnt_q <= 3'd0;
            shift_q  <= 8'd0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            divCnt_q <= divCnt_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef TX_PARITY_EN
    // Parity bit is fixed from the byte captured at accept time.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign serial_data_out = line_q;
    assign busy            = busy_q;
    assign tx_done         = done_q;

endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: randomized self-checking bench for the UART transmitter.
// Frames are predicted bit-by-bit from the byte value and the frame layout.
module tb_transmitter;

    localparam int C = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sys_clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] parallel_data_in;
    logic       serial_data_out;
    logic       busy;
    logic       tx_done;

    int testsRun;
    int testsFailed;

    transmitter #(.CLKS_PER_BIT(C)) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .tx_start         (tx_start),
        .parallel_data_in (parallel_data_in),
        .serial_data_out  (serial_data_out),
        .busy             (busy),
        .tx_done          (tx_done)
    );

    // Free-running system clock, 10 time units per period.
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Expected line value for frame bit index idx of byte b.
    function automatic logic expectedBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 1 && idx <= 8) return b[idx-1];
`ifdef TX_PARITY_EN
        if (idx == 9) return (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
`endif
        return 1'b1;
    endfunction

    // Request a frame; returns at the falling edge just after the accept edge.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge sys_clk);
        tx_start         = 1'b1;
        parallel_data_in = b;
        @(negedge sys_clk);
    endtask

    // Follow a whole frame from cycle 0, optionally poking tx_start at pokeCycle
    // or holding tx_start high throughout, then check the frame-end cycle.
    task automatic checkOutput(input logic [7:0] b, input string tag,
                               input int pokeCycle, input bit keepStart);
        for (int c = 0; c < NBITS * C; c++) begin
            if (!keepStart) begin
                tx_start = (c == pokeCycle);
                parallel_data_in = (c == pokeCycle) ? 8'hFF : 8'($urandom);
            end
            testsRun++;
            if (serial_data_out !== expectedBit(b, c / C)) begin
                testsFailed++;
                $display("[TB] FAIL %s line cycle %0d got %b expected %b",
                         tag, c, serial_data_out, expectedBit(b, c / C));
            end
            testsRun++;
            if (busy !== 1'b1 || tx_done !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL %s busy/done cycle %0d got %b/%b expected 1/0",
                         tag, c, busy, tx_done);
            end
            @(negedge sys_clk);
        end
        testsRun++;
        if (busy !== 1'b0 || tx_done !== 1'b1 || serial_data_out !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s frame end busy/done/line got %b/%b/%b expected 0/1/1",
                     tag, busy, tx_done, serial_data_out);
        end
        if (!keepStart) begin
            tx_start = 1'b0;
            @(negedge sys_clk);
            testsRun++;
            if (busy !== 1'b0 || tx_done !== 1'b0 || serial_data_out !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL %s after end busy/done/line got %b/%b/%b expected 0/0/1",
                         tag, busy, tx_done, serial_data_out);
            end
        end
    endtask

    // Reset values and a quiet idle period.
    task automatic test_reset();
        rst_n            = 1'b0;
        tx_start         = 1'b0;
        parallel_data_in = 8'h00;
        repeat (3) begin
            @(negedge sys_clk);
            testsRun++;
            if (serial_data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset line/busy/done got %b/%b/%b expected 1/0/0",
                         serial_data_out, busy, tx_done);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            parallel_data_in = 8'($urandom);
            @(negedge sys_clk);
            testsRun++;
            if (serial_data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL idle cycle %0d line/busy/done got %b/%b/%b expected 1/0/0",
                         i, serial_data_out, busy, tx_done);
            end
        end
    endtask

    // Known byte 0xA5.
    task automatic test_single_frame();
        applyStimulus(8'hA5);
        checkOutput(8'hA5, "single_A5", -1, 1'b0);
    endtask

    // Parity polarity for one set bit and for all zeros.
    task automatic test_parity();
        applyStimulus(8'h01);
        checkOutput(8'h01, "parity_01", -1, 1'b0);
        applyStimulus(8'h00);
        checkOutput(8'h00, "parity_00", -1, 1'b0);
    endtask

    // Random bytes with random gaps.
    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            applyStimulus(b);
            checkOutput(b, "random", -1, 1'b0);
        end
    endtask

    // A request during a frame must be dropped.
    task automatic test_ignored();
        applyStimulus(8'h3C);
        checkOutput(8'h3C, "ignored_3C", 10, 1'b0);
    endtask

    // tx_start held high across two frames.
    task automatic test_back_to_back();
        applyStimulus(8'h55);
        parallel_data_in = 8'hAA;
        checkOutput(8'h55, "b2b_first", -1, 1'b1);
        @(negedge sys_clk);
        checkOutput(8'hAA, "b2b_second", -1, 1'b0);
    endtask

    // Asynchronous reset during data bit 3, then a clean frame.
    task automatic test_reset_mid();
        applyStimulus(8'hF0);
        tx_start = 1'b0;
        repeat (4 * C + 1) @(negedge sys_clk);
        testsRun++;
        if (serial_data_out !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midreset pre line/busy got %b/%b expected 0/1",
                     serial_data_out, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (serial_data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset async line/busy/done got %b/%b/%b expected 1/0/0",
                     serial_data_out, busy, tx_done);
        end
        repeat (2) begin
            @(negedge sys_clk);
            testsRun++;
            if (serial_data_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL midreset held line/busy/done got %b/%b/%b expected 1/0/0",
                         serial_data_out, busy, tx_done);
            end
        end
        rst_n = 1'b1;
        applyStimulus(8'h12);
        checkOutput(8'h12, "after_reset_12", -1, 1'b0);
    endtask

    // Run every scenario in order and report.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_single_frame();
        test_parity();
        test_random();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
